adder_scheduler: RTL and testbench
==================================

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 Parameter: RR, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1  requester n has an operation pending; held high until its gnt pulse.
REQ-005 wide0 / wide1  input  1  requester n operation width: 0 = 16-bit, 1 = 32-bit.
REQ-006 a0, b0 / a1, b1  input  32  requester n operands; only [15:0] used when wide = 0.
REQ-007 cin0 / cin1  input  1  requester n carry-in.
REQ-008 gnt0 / gnt1  output  1  one-cycle pulse: requester n operands captured this edge.
REQ-009 done0 / done1  output  1  one-cycle pulse: result/cout valid for requester n.
REQ-010 result  output  32  registered sum of the last completed operation.
REQ-011 cout  output  1  registered carry-out of the last completed operation.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Block SHALL contain exactly one instance of the team's 16-bit ripple-carry adder (full_adder) and SHALL time-share it between both requesters.
REQ-014 FSM states SHALL be IDLE, LOW, HIGH, DONE; reset state IDLE.
REQ-015 Requests SHALL be sampled only in IDLE; req inputs in other states are ignored.
REQ-016 In IDLE with any req high: arbitrate, pulse the winner's gnt in that cycle (combinational from state and req), capture its a, b, cin, wide and requester id into internal registers at the edge, go to LOW.
REQ-017 RR = 1: a lone requester wins; with both high, the requester not served last wins; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-018 RR = 0: requester 0 always wins ties.
REQ-019 LOW: adder inputs = captured a[15:0], b[15:0], cin; register sum into result[15:0] and carry into an internal carry register; next state HIGH if wide else DONE.
REQ-020 HIGH: adder inputs = captured a[31:16], b[31:16], internal carry; register sum into result[31:16] and carry into cout; next state DONE.
REQ-021 Narrow operation SHALL clear result[31:16] to 0 and load cout with the low-half carry in LOW.
REQ-022 DONE: pulse done of the captured requester for exactly one cycle, update last-served pointer, go to IDLE.
REQ-023 Latency from gnt cycle T: done at T+2 (narrow), T+3 (wide); back-to-back throughput one operation per 3 (narrow) / 4 (wide) cycles.
REQ-024 result and cout SHALL hold their value from DONE until the next operation's LOW cycle overwrites them.
REQ-025 Arithmetic is modulo 2^16 / 2^32; overflow is reported only through cout, no other flag.
REQ-026 gnt and done SHALL never be high for both requesters in the same cycle; gnt and done never coincide.

Reset
REQ-027 On rst high at a clock edge: state IDLE, result 0, cout 0, internal carry 0, last-served pointer 1, all captured registers 0.
REQ-028 gnt0, gnt1, done0, done1, busy SHALL be 0 while rst is high and in the cycle after.
REQ-029 Reset mid-operation SHALL abort it with no done pulse; requester must re-request.

Verification
REQ-030 Narrow: req0, a0=0x0000FFFF, b0=0x00000001, cin0=0 -> gnt0 at T, done0 at T+2, result=0x00000000, cout=1.
REQ-031 Wide: req1, wide1=1, a1=0x0001FFFF, b1=0x00000001, cin1=1 -> done1 at T+3, result=0x00020001, cout=0; a1=b1=0xFFFFFFFF, cin1=0 -> result=0xFFFFFFFE, cout=1.
REQ-032 Tie, RR=1: req0 and req1 held continuously from reset -> grant order 0,1,0,1; no cycle with both gnt or both done.
REQ-033 Tie, RR=0: same stimulus -> gnt0 every operation, gnt1 never.
REQ-034 Reset in HIGH of a wide operation -> no done pulse, result=0, cout=0, busy=0 next cycle, next tie grants requester 0.
REQ-035 req1 raised while busy with requester 0 -> ignored until IDLE, then gnt1 in the first IDLE cycle after done0.

Source files
------------

// File: rtl/adder_scheduler_if.sv
// Request/grant/result bundle between two requesters and the shared adder scheduler.
// Latency: none (wires only).
// Backpressure: req is held by the requester until gnt; done is an unacknowledged pulse.
interface adder_scheduler_if;
  logic        req0;
  logic        req1;
  logic        wide0;
  logic        wide1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        cin0;
  logic        cin1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic        cout;
  logic        busy;

  // Requester side: raises requests and operands, observes grants and results.
  modport master (
    output req0, req1, wide0, wide1, a0, b0, a1, b1, cin0, cin1,
    input  gnt0, gnt1, done0, done1, result, cout, busy
  );

  // Scheduler side.
  modport slave (
    input  req0, req1, wide0, wide1, a0, b0, a1, b1, cin0, cin1,
    output gnt0, gnt1, done0, done1, result, cout, busy
  );
endinterface

// File: rtl/adder_scheduler.sv
// Time-shares one 16-bit ripple-carry adder between two requesters (16- or 32-bit adds).
// Latency: done 2 cycles after gnt for 16-bit, 3 cycles for 32-bit.
// Backpressure: requests are only sampled in IDLE; a requester holds req until its gnt pulse.

// 16-bit ripple-carry adder shared by the scheduler below.
module full_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  // Ripple the carry through 16 single-bit full-adder cells.
  always_comb begin : ripple
    logic w_c;
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < 16; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end
endmodule

module adder_scheduler #(
  parameter bit RR = 1'b1  // 1: round-robin on ties, 0: requester 0 always wins ties
) (
  input  logic             clk,
  input  logic             rst,
  adder_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rst_d;    // high for the first cycle after reset is released
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_cin;
  logic        r_wide;
  logic        r_id;       // requester that owns the operation in flight
  logic        r_carry;    // carry from the low half into the high half
  logic        r_last;     // requester served last (tie-break pointer)
  logic [31:0] r_result;
  logic        r_cout;

  logic        w_quiet;
  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_done0;
  logic        w_done1;
  logic [15:0] w_add_a;
  logic [15:0] w_add_b;
  logic        w_add_cin;
  logic [15:0] w_sum;
  logic        w_add_cout;

  // Handshake outputs stay low during reset and the cycle right after it.
  assign w_quiet = rst | r_rst_d;

  // State register and post-reset quiet flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rst_d <= 1'b1;
    end else begin
      r_state <= w_next;
      r_rst_d <= 1'b0;
    end
  end

  // Arbitration, next-state decode and grant/done pulses.
  always_comb begin
    w_next  = r_state;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    // On a tie, round-robin picks requester 1 only if requester 0 was served last.
    if (bus.req0 && bus.req1) w_pick1 = RR ? ~r_last : 1'b0;
    else                      w_pick1 = bus.req1;
    case (r_state)
      IDLE: begin
        if (!w_quiet && (bus.req0 || bus.req1)) begin
          w_gnt0 = ~w_pick1;
          w_gnt1 = w_pick1;
          w_next = LOW;
        end
      end
      LOW:  w_next = r_wide ? HIGH : DONE;
      HIGH: w_next = DONE;
      DONE: begin
        w_done0 = ~w_quiet & ~r_id;
        w_done1 = ~w_quiet & r_id;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Steer the shared adder: low halves with the requester's carry-in, then high halves.
  always_comb begin
    if (r_state == HIGH) begin
      w_add_a   = r_a[31:16];
      w_add_b   = r_b[31:16];
      w_add_cin = r_carry;
    end else begin
      w_add_a   = r_a[15:0];
      w_add_b   = r_b[15:0];
      w_add_cin = r_cin;
    end
  end

  full_adder u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_add_cout)
  );

  // Operand capture at grant, half-result registration, and tie pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_wide   <= 1'b0;
      r_id     <= 1'b0;
      r_carry  <= 1'b0;
      r_last   <= 1'b1;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a    <= w_gnt1 ? bus.a1    : bus.a0;
            r_b    <= w_gnt1 ? bus.b1    : bus.b0;
            r_cin  <= w_gnt1 ? bus.cin1  : bus.cin0;
            r_wide <= w_gnt1 ? bus.wide1 : bus.wide0;
            r_id   <= w_gnt1;
          end
        end
        LOW: begin
          r_result[15:0] <= w_sum;
          r_carry        <= w_add_cout;
          // A 16-bit operation finishes here: upper half zero, carry-out is the low carry.
          if (!r_wide) begin
            r_result[31:16] <= '0;
            r_cout          <= w_add_cout;
          end
        end
        HIGH: begin
          r_result[31:16] <= w_sum;
          r_cout          <= w_add_cout;
        end
        DONE: r_last <= r_id;
        default: ;
      endcase
    end
  end

  assign bus.gnt0   = w_gnt0;
  assign bus.gnt1   = w_gnt1;
  assign bus.done0  = w_done0;
  assign bus.done1  = w_done1;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.busy   = (r_state != IDLE) & ~w_quiet;
endmodule

// File: tb/tb_adder_scheduler.sv
// Scoreboard bench for adder_scheduler: one round-robin instance, one fixed-priority instance.
// Latency: checks done arrives 2 (narrow) / 3 (wide) cycles after gnt.
// Backpressure: requesters hold req until gnt, then drop it.
module tb_adder_scheduler;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   b_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_scheduler_if ifa ();
  adder_scheduler_if ifb ();

  adder_scheduler #(.RR(1'b1)) dut_rr (.clk(clk), .rst(rst_a), .bus(ifa));
  adder_scheduler #(.RR(1'b0)) dut_fp (.clk(clk), .rst(rst_b), .bus(ifb));

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        cout;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse of the round-robin instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      checkb("excl", (ifa.gnt0 & ifa.gnt1) | (ifa.done0 & ifa.done1) |
                     ((ifa.gnt0 | ifa.gnt1) & (ifa.done0 | ifa.done1)), 1'b0);
      if (ifa.done0 | ifa.done1) begin
        if (sb.size() == 0) begin
          checkb("unexpected_done", ifa.done0 | ifa.done1, 1'b0);
        end else begin
          e = sb.pop_front();
          check32("done_id", ifa.done1 ? 1 : 0, e.id);
          check32("result", ifa.result, e.res);
          checkb("cout", ifa.cout, e.cout);
          check32("latency", cyc - e.gcyc, e.lat);
        end
      end
    end
  end

  task automatic drive(input int id, input logic req, input logic wide,
                       input logic [31:0] a, input logic [31:0] b, input logic cin);
    if (id == 0) begin
      ifa.req0 = req; ifa.wide0 = wide; ifa.a0 = a; ifa.b0 = b; ifa.cin0 = cin;
    end else begin
      ifa.req1 = req; ifa.wide1 = wide; ifa.a1 = a; ifa.b1 = b; ifa.cin1 = cin;
    end
  endtask

  // want: 0 or 1 for a specific requester, 2 for either. Returns at the negedge after the grant.
  task automatic wait_gnt(input int want, output int gc, output int who);
    gc  = -1;
    who = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ifa.gnt0 && want != 1) begin who = 0; gc = cyc; break; end
      if (ifa.gnt1 && want != 0) begin who = 1; gc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (gc < 0) begin
      bad++;
      $display("FAIL gnt_wait: no grant for %0d within 20 cycles (cycle %0d)", want, cyc);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic push(input int id, input logic wide, input logic [31:0] er,
                      input logic ec, input int gc);
    exp_t e;
    e.id = id; e.res = er; e.cout = ec; e.gcyc = gc; e.lat = wide ? 3 : 2;
    sb.push_back(e);
  endtask

  task automatic issue(input int id, input logic wide, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input logic [31:0] er,
                       input logic ec, output int gc);
    int who;
    drive(id, 1'b1, wide, a, b, cin);
    wait_gnt(id, gc, who);
    if (id == 0) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
    if (gc >= 0) push(id, wide, er, ec, gc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ifa.busy || sb.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 30) begin
      bad++;
      $display("FAIL idle_wait: busy=%b pending=%0d after 30 cycles", ifa.busy, sb.size());
    end
  endtask

  // Round-robin instance: directed vectors.
  initial begin
    int gc, gc0, who;
    int g[4];
    // Tie from reset: requester 0 narrow, requester 1 wide.
    drive(0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_1111, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    rst_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check32("rst_outs", {27'd0, ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.busy}, 32'd0);
    end
    rst_a = 1'b0;
    #1;
    check32("post_rst_hs", {29'd0, ifa.gnt0, ifa.gnt1, ifa.busy}, 32'd0);
    check32("post_rst_result", ifa.result, 32'd0);
    checkb("post_rst_cout", ifa.cout, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      wait_gnt(2, gc, who);
      g[k] = gc;
      check32("tie_order", who, k % 2);
      if (k == 3) begin ifa.req0 = 1'b0; ifa.req1 = 1'b0; end
      if (who == 0) push(0, 1'b0, 32'h0000_2345, 1'b0, gc);
      else if (who == 1) push(1, 1'b1, 32'h0000_0001, 1'b1, gc);
    end
    check32("rate_narrow", g[1] - g[0], 3);
    check32("rate_wide", g[2] - g[1], 4);
    wait_idle();

    // Narrow carry out of bit 15.
    issue(0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, gc);
    wait_idle();
    repeat (3) @(negedge clk);
    check32("hold_result", ifa.result, 32'h0000_0000);
    checkb("hold_cout", ifa.cout, 1'b1);

    // Wide with carry-in and carry across halves.
    issue(1, 1'b1, 32'h0001_FFFF, 32'h0000_0001, 1'b1, 32'h0002_0001, 1'b0, gc);
    wait_idle();
    issue(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, gc);
    wait_idle();
    // Narrow after wide: upper operand bits ignored, upper result cleared.
    issue(1, 1'b0, 32'hABCD_1234, 32'h1111_0001, 1'b1, 32'h0000_1236, 1'b0, gc);
    wait_idle();

    // Request from 1 arriving while 0 is in flight is granted right after done0.
    issue(0, 1'b0, 32'h0000_0100, 32'h0000_0200, 1'b0, 32'h0000_0300, 1'b0, gc0);
    drive(1, 1'b1, 1'b0, 32'h0000_0009, 32'h0000_0001, 1'b0);
    wait_gnt(1, gc, who);
    ifa.req1 = 1'b0;
    if (gc >= 0) push(1, 1'b0, 32'h0000_000A, 1'b0, gc);
    check32("late_req_gnt", gc - gc0, 3);
    wait_idle();

    // Reset during HIGH of a wide op, after requester 0 was served last.
    issue(0, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 1'b0, gc);
    wait_idle();
    issue(1, 1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, gc);
    @(negedge clk);
    void'(sb.pop_back());
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    #1;
    check32("abort_hs", {27'd0, ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.busy}, 32'd0);
    check32("abort_result", ifa.result, 32'd0);
    checkb("abort_cout", ifa.cout, 1'b0);
    @(negedge clk);
    wait_gnt(2, gc, who);
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    check32("abort_tie_winner", who, 0);
    if (who == 0) push(0, 1'b0, 32'h0000_0030, 1'b0, gc);
    else if (who == 1) push(1, 1'b1, 32'h0000_0002, 1'b0, gc);
    wait_idle();

    wait (b_done);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Fixed-priority instance: both requesters held high, requester 1 must never win.
  initial begin
    int ng = 0;
    ifb.req0 = 1'b1; ifb.wide0 = 1'b0; ifb.a0 = 32'd3; ifb.b0 = 32'd4; ifb.cin0 = 1'b0;
    ifb.req1 = 1'b1; ifb.wide1 = 1'b1; ifb.a1 = 32'd1; ifb.b1 = 32'd1; ifb.cin1 = 1'b0;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checkb("fp_gnt1", ifb.gnt1, 1'b0);
      checkb("fp_done1", ifb.done1, 1'b0);
      if (ifb.gnt0) ng++;
      if (ifb.done0) check32("fp_result", ifb.result, 32'd7);
    end
    total++;
    if (ng < 15) begin
      bad++;
      $display("FAIL fp_gnt0_count: got %0d want at least 15", ng);
    end
    b_done = 1'b1;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end
endmodule
